// File: rtl/alu_rs_if.sv
// +----------------------------------------------------------------------+
// | alu_rs_if : ALU issue bundle between the reservation station and ALU |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

interface alu_rs_if #(
  parameter int DATA_LEN     = 32,
  parameter int ALU_OP_WIDTH = 4,
  parameter int RRF_SEL      = 6
);
  logic                    issue_o;
  logic [ALU_OP_WIDTH-1:0] alu_op_o;
  logic [DATA_LEN-1:0]     src1_o;
  logic [DATA_LEN-1:0]     src2_o;
  logic [RRF_SEL-1:0]      rrftag_o;
  logic                    if_write_rrf_o;

  modport master (
    output issue_o, alu_op_o, src1_o, src2_o, rrftag_o, if_write_rrf_o
  );

  modport slave (
    input issue_o, alu_op_o, src1_o, src2_o, rrftag_o, if_write_rrf_o
  );
endinterface

`default_nettype wire

// File: rtl/alu_rs.sv
// +----------------------------------------------------------------------+
// | alu_rs : ALU reservation station, operand wakeup and in-order select |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module alu_rs #(
  parameter int DATA_LEN     = 32,
  parameter int ALU_OP_WIDTH = 4,
  parameter int RRF_SEL      = 6,
  parameter int RS_ENT_NUM   = 4,
  parameter int RS_ENT_SEL   = 2
) (
  input  wire logic                    clk,
  input  wire logic                    reset,
  input  wire logic                    flush_i,
  input  wire logic                    dispatch_we_i,
  input  wire logic [ALU_OP_WIDTH-1:0] dispatch_alu_op_i,
  input  wire logic [DATA_LEN-1:0]     dispatch_src1_i,
  input  wire logic                    dispatch_src1_valid_i,
  input  wire logic [DATA_LEN-1:0]     dispatch_src2_i,
  input  wire logic                    dispatch_src2_valid_i,
  input  wire logic [RRF_SEL-1:0]      dispatch_rrftag_i,
  input  wire logic                    dispatch_if_write_rrf_i,
  input  wire logic                    wb_valid_i,
  input  wire logic [RRF_SEL-1:0]      wb_rrftag_i,
  input  wire logic [DATA_LEN-1:0]     wb_result_i,
  output logic                         full_o,
  alu_rs_if.master                     issue_if
);

  logic [RS_ENT_NUM-1:0]   r_busy;
  logic [RS_ENT_NUM-1:0]   r_src1_v;
  logic [RS_ENT_NUM-1:0]   r_src2_v;
  logic [RS_ENT_NUM-1:0]   r_wr;
  logic [ALU_OP_WIDTH-1:0] r_op   [RS_ENT_NUM];
  logic [DATA_LEN-1:0]     r_src1 [RS_ENT_NUM];
  logic [DATA_LEN-1:0]     r_src2 [RS_ENT_NUM];
  logic [RRF_SEL-1:0]      r_tag  [RS_ENT_NUM];

  logic [RS_ENT_NUM-1:0] w_ready;
  logic                  w_free_found;
  logic [RS_ENT_SEL-1:0] w_free_idx;
  logic                  w_rdy_found;
  logic [RS_ENT_SEL-1:0] w_rdy_idx;
  logic                  w_issue;
  logic                  w_dispatch;
  logic                  w_d_src1_v;
  logic                  w_d_src2_v;
  logic [DATA_LEN-1:0]   w_d_src1;
  logic [DATA_LEN-1:0]   w_d_src2;

  assign w_ready = r_busy & r_src1_v & r_src2_v;

  // Descending scan so the lowest matching index is the last one written.
  always_comb begin
    w_free_found = 1'b0;
    w_free_idx   = '0;
    w_rdy_found  = 1'b0;
    w_rdy_idx    = '0;
    for (int i = RS_ENT_NUM - 1; i >= 0; i--) begin
      if (!r_busy[i]) begin
        w_free_found = 1'b1;
        w_free_idx   = RS_ENT_SEL'(i);
      end
      if (w_ready[i]) begin
        w_rdy_found = 1'b1;
        w_rdy_idx   = RS_ENT_SEL'(i);
      end
    end
  end

  assign full_o     = reset && !w_free_found;
  assign w_dispatch = dispatch_we_i && !full_o;
  assign w_issue    = reset && !flush_i && w_rdy_found;

  always_comb begin
    w_d_src1   = dispatch_src1_i;
    w_d_src1_v = dispatch_src1_valid_i;
    w_d_src2   = dispatch_src2_i;
    w_d_src2_v = dispatch_src2_valid_i;
    if (!dispatch_src1_valid_i && wb_valid_i &&
        (dispatch_src1_i[RRF_SEL-1:0] == wb_rrftag_i)) begin
      w_d_src1   = wb_result_i;
      w_d_src1_v = 1'b1;
    end
    if (!dispatch_src2_valid_i && wb_valid_i &&
        (dispatch_src2_i[RRF_SEL-1:0] == wb_rrftag_i)) begin
      w_d_src2   = wb_result_i;
      w_d_src2_v = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset || flush_i) begin
      r_busy <= '0;
    end else begin
      for (int i = 0; i < RS_ENT_NUM; i++) begin
        if (w_dispatch && (w_free_idx == RS_ENT_SEL'(i))) begin
          r_busy[i]   <= 1'b1;
          r_op[i]     <= dispatch_alu_op_i;
          r_src1[i]   <= w_d_src1;
          r_src1_v[i] <= w_d_src1_v;
          r_src2[i]   <= w_d_src2;
          r_src2_v[i] <= w_d_src2_v;
          r_tag[i]    <= dispatch_rrftag_i;
          r_wr[i]     <= dispatch_if_write_rrf_i;
        end else begin
          if (w_issue && (w_rdy_idx == RS_ENT_SEL'(i))) begin
            r_busy[i] <= 1'b0;
          end
          if (r_busy[i] && !r_src1_v[i] && wb_valid_i &&
              (r_src1[i][RRF_SEL-1:0] == wb_rrftag_i)) begin
            r_src1[i]   <= wb_result_i;
            r_src1_v[i] <= 1'b1;
          end
          if (r_busy[i] && !r_src2_v[i] && wb_valid_i &&
              (r_src2[i][RRF_SEL-1:0] == wb_rrftag_i)) begin
            r_src2[i]   <= wb_result_i;
            r_src2_v[i] <= 1'b1;
          end
        end
      end
    end
  end

  assign issue_if.issue_o        = w_issue;
  assign issue_if.alu_op_o       = w_issue ? r_op[w_rdy_idx]   : '0;
  assign issue_if.src1_o         = w_issue ? r_src1[w_rdy_idx] : '0;
  assign issue_if.src2_o         = w_issue ? r_src2[w_rdy_idx] : '0;
  assign issue_if.rrftag_o       = w_issue ? r_tag[w_rdy_idx]  : '0;
  assign issue_if.if_write_rrf_o = w_issue && r_wr[w_rdy_idx];

endmodule

`default_nettype wire

// File: tb/tb_alu_rs.sv
// +----------------------------------------------------------------------+
// | tb_alu_rs : directed self-checking bench for the ALU reservation stn |
// | Revision  : 1.0                                                      |
// +----------------------------------------------------------------------+
`default_nettype none

module tb_alu_rs;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush_i;
  logic        dispatch_we_i;
  logic [3:0]  dispatch_alu_op_i;
  logic [31:0] dispatch_src1_i;
  logic        dispatch_src1_valid_i;
  logic [31:0] dispatch_src2_i;
  logic        dispatch_src2_valid_i;
  logic [5:0]  dispatch_rrftag_i;
  logic        dispatch_if_write_rrf_i;
  logic        wb_valid_i;
  logic [5:0]  wb_rrftag_i;
  logic [31:0] wb_result_i;
  logic        full_o;

  int checks = 0;
  int errors = 0;

  alu_rs_if #(.DATA_LEN(32), .ALU_OP_WIDTH(4), .RRF_SEL(6)) iss_if ();

  alu_rs #(
    .DATA_LEN(32), .ALU_OP_WIDTH(4), .RRF_SEL(6), .RS_ENT_NUM(4), .RS_ENT_SEL(2)
  ) dut (
    .clk                     (clk),
    .reset                   (reset),
    .flush_i                 (flush_i),
    .dispatch_we_i           (dispatch_we_i),
    .dispatch_alu_op_i       (dispatch_alu_op_i),
    .dispatch_src1_i         (dispatch_src1_i),
    .dispatch_src1_valid_i   (dispatch_src1_valid_i),
    .dispatch_src2_i         (dispatch_src2_i),
    .dispatch_src2_valid_i   (dispatch_src2_valid_i),
    .dispatch_rrftag_i       (dispatch_rrftag_i),
    .dispatch_if_write_rrf_i (dispatch_if_write_rrf_i),
    .wb_valid_i              (wb_valid_i),
    .wb_rrftag_i             (wb_rrftag_i),
    .wb_result_i             (wb_result_i),
    .full_o                  (full_o),
    .issue_if                (iss_if)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush_i                 = 1'b0;
    dispatch_we_i           = 1'b0;
    dispatch_alu_op_i       = '0;
    dispatch_src1_i         = '0;
    dispatch_src1_valid_i   = 1'b0;
    dispatch_src2_i         = '0;
    dispatch_src2_valid_i   = 1'b0;
    dispatch_rrftag_i       = '0;
    dispatch_if_write_rrf_i = 1'b0;
    wb_valid_i              = 1'b0;
    wb_rrftag_i             = '0;
    wb_result_i             = '0;
  endtask

  task automatic dsp(input logic [3:0] op, input logic [31:0] s1, input logic v1,
                     input logic [31:0] s2, input logic v2, input logic [5:0] tag,
                     input logic wr);
    dispatch_we_i           = 1'b1;
    dispatch_alu_op_i       = op;
    dispatch_src1_i         = s1;
    dispatch_src1_valid_i   = v1;
    dispatch_src2_i         = s2;
    dispatch_src2_valid_i   = v2;
    dispatch_rrftag_i       = tag;
    dispatch_if_write_rrf_i = wr;
  endtask

  task automatic wb(input logic [5:0] tag, input logic [31:0] val);
    wb_valid_i  = 1'b1;
    wb_rrftag_i = tag;
    wb_result_i = val;
  endtask

  initial begin
    reset = 1'b0;
    idle();
    step();
    step();
    chk("rst_full", full_o, 0);
    chk("rst_issue", iss_if.issue_o, 0);
    chk("rst_op", iss_if.alu_op_o, 0);
    chk("rst_src1", iss_if.src1_o, 0);
    chk("rst_tag", iss_if.rrftag_o, 0);
    chk("rst_wr", iss_if.if_write_rrf_o, 0);
    reset = 1'b1;

    // Ready-at-dispatch op issues the following cycle only.
    dsp(4'd1, 32'd5, 1'b1, 32'd7, 1'b1, 6'd3, 1'b1);
    #1 chk("t1_no_issue_disp", iss_if.issue_o, 0);
    step(); idle(); #1;
    chk("t1_issue", iss_if.issue_o, 1);
    chk("t1_op", iss_if.alu_op_o, 1);
    chk("t1_src1", iss_if.src1_o, 5);
    chk("t1_src2", iss_if.src2_o, 7);
    chk("t1_tag", iss_if.rrftag_o, 3);
    chk("t1_wr", iss_if.if_write_rrf_o, 1);
    step();
    chk("t1_after", iss_if.issue_o, 0);
    chk("t1_after_src1", iss_if.src1_o, 0);

    // Wakeup from broadcast two cycles after dispatch.
    dsp(4'd2, 32'd1, 1'b1, 32'd9, 1'b0, 6'd4, 1'b1);
    step(); idle(); #1;
    chk("t2_wait1", iss_if.issue_o, 0);
    step(); wb(6'd9, 32'h20); #1;
    chk("t2_bcast_cycle", iss_if.issue_o, 0);
    step(); idle(); #1;
    chk("t2_issue", iss_if.issue_o, 1);
    chk("t2_src1", iss_if.src1_o, 1);
    chk("t2_src2", iss_if.src2_o, 32'h20);
    chk("t2_tag", iss_if.rrftag_o, 4);
    step();
    chk("t2_after", iss_if.issue_o, 0);

    // Dispatch bypass from same-cycle broadcast.
    dsp(4'd3, 32'd2, 1'b1, 32'd9, 1'b0, 6'd5, 1'b0);
    wb(6'd9, 32'h11);
    step(); idle(); #1;
    chk("t3_issue", iss_if.issue_o, 1);
    chk("t3_src2", iss_if.src2_o, 32'h11);
    chk("t3_tag", iss_if.rrftag_o, 5);
    chk("t3_wr", iss_if.if_write_rrf_o, 0);
    step();
    chk("t3_after", iss_if.issue_o, 0);

    // Fill: entries 0 and 2 wait on tag 10, entry 1 on 11, entry 3 on 13.
    for (int i = 0; i < 4; i++) begin
      dsp(4'd4, 32'(i), 1'b1, (i % 2 == 0) ? 32'd10 : 32'(10 + i), 1'b0, 6'(20 + i), 1'b1);
      #1 chk("t4_not_full", full_o, 0);
      step();
    end
    idle(); #1;
    chk("t4_full", full_o, 1);
    chk("t4_full_noissue", iss_if.issue_o, 0);
    dsp(4'd5, 32'd1, 1'b1, 32'd2, 1'b1, 6'd30, 1'b1);
    #1 chk("t4_full_at_drop", full_o, 1);
    step(); idle(); #1;
    chk("t4_drop_noissue", iss_if.issue_o, 0);
    chk("t4_drop_full", full_o, 1);
    wb(6'd10, 32'h55); #1;
    chk("t4_wake_cycle", iss_if.issue_o, 0);
    step(); idle(); #1;
    chk("t4_e0_issue", iss_if.issue_o, 1);
    chk("t4_e0_tag", iss_if.rrftag_o, 20);
    chk("t4_e0_src1", iss_if.src1_o, 0);
    chk("t4_e0_src2", iss_if.src2_o, 32'h55);
    chk("t4_e0_full", full_o, 1);
    step();
    chk("t4_e2_issue", iss_if.issue_o, 1);
    chk("t4_e2_tag", iss_if.rrftag_o, 22);
    chk("t4_e2_src1", iss_if.src1_o, 2);
    chk("t4_e2_full", full_o, 0);
    step();
    chk("t4_drained", iss_if.issue_o, 0);

    // Three busy (one ready), flush with a concurrent dispatch.
    dsp(4'd6, 32'd8, 1'b1, 32'd9, 1'b1, 6'd41, 1'b1);
    step(); idle();
    flush_i = 1'b1;
    dsp(4'd7, 32'd1, 1'b1, 32'd1, 1'b1, 6'd40, 1'b1);
    #1 chk("t5_flush_noissue", iss_if.issue_o, 0);
    chk("t5_flush_src1", iss_if.src1_o, 0);
    step(); idle(); #1;
    chk("t5_full", full_o, 0);
    chk("t5_issue", iss_if.issue_o, 0);
    wb(6'd11, 32'h66);
    step(); idle(); #1;
    chk("t5_after_wb11", iss_if.issue_o, 0);
    wb(6'd13, 32'h67);
    step(); idle(); #1;
    chk("t5_after_wb13", iss_if.issue_o, 0);

    // Reset with ready entries pending.
    dsp(4'd8, 32'd3, 1'b1, 32'd60, 1'b0, 6'd50, 1'b1);
    step();
    dsp(4'd9, 32'd4, 1'b1, 32'd60, 1'b0, 6'd51, 1'b1);
    step(); idle();
    wb(6'd60, 32'h77);
    step(); idle();
    reset = 1'b0;
    #1;
    chk("t6_rst_issue", iss_if.issue_o, 0);
    chk("t6_rst_op", iss_if.alu_op_o, 0);
    chk("t6_rst_full", full_o, 0);
    step();
    reset = 1'b1;
    #1 chk("t6_post1", iss_if.issue_o, 0);
    step();
    chk("t6_post2", iss_if.issue_o, 0);
    dsp(4'd10, 32'd6, 1'b1, 32'd7, 1'b1, 6'd52, 1'b1);
    step(); idle(); #1;
    chk("t6_recover_issue", iss_if.issue_o, 1);
    chk("t6_recover_tag", iss_if.rrftag_o, 52);
    chk("t6_recover_op", iss_if.alu_op_o, 10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
